// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction constants.
// Used by the Gray counter and by later async-FIFO pointer logic.
//   GRAY_MAX_WIDTH : widest value the helper functions handle
//   DIR_UP/DIR_DOWN: encodings of the counter Up input
//   bin2gray()     : binary -> Gray (zero-extended values of any width)
//   gray2bin()     : Gray -> binary (zero-extended values of any width)
package gray_pkg;

    localparam int unsigned GRAY_MAX_WIDTH = 32;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Narrower values are passed zero-extended; the unused upper bits stay zero
    // through both conversions, so callers simply truncate the result.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] gray
    );
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Combinational binary-to-Gray converter of parametrised width.
// Ports:
//   bin  : binary input value
//   gray : Gray-coded equivalent of bin
module bin2gray_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    if (WIDTH < 1 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("bin2gray_n: WIDTH out of range");
    end

    assign gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with synchronous load, sticky
// overflow and a one-cycle wrap pulse. All outputs are registered.
// Parameters:
//   WIDTH         : counter width in bits (>= 2)
//   OVF_CLEARABLE : 1 lets OvfClr clear Overflow; 0 leaves it to Reset only
// Ports:
//   Clk      : rising-edge clock
//   Reset    : asynchronous active-low reset
//   En       : count enable, one step per enabled cycle
//   Up       : direction, 1 = increment, 0 = decrement
//   Load     : synchronous load strobe (beats En/Up)
//   LoadVal  : binary value to load
//   OvfClr   : synchronous clear of Overflow
//   Output   : registered Gray-coded count
//   BinOut   : registered binary count
//   Overflow : sticky flag, set on any wrap in either direction
//   Wrap     : pulse in the cycle after a wrap step
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH         = 3,
    parameter bit          OVF_CLEARABLE = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             OvfClr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Wrap
);

    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("gray_counter_n: WIDTH out of range");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (OVF_CLEARABLE && OvfClr) begin
            ovf_d = 1'b0;
        end

        if (Load) begin
            cnt_d = LoadVal;
        end else if (En) begin
            if (Up == DIR_UP) begin
                cnt_d  = cnt_q + WIDTH'(1);
                wrap_d = (cnt_q == '1);
            end else begin
                cnt_d  = cnt_q - WIDTH'(1);
                wrap_d = (cnt_q == '0);
            end
        end

        // A wrap on the same edge as OvfClr keeps the flag set.
        if (wrap_d) begin
            ovf_d = 1'b1;
        end
    end

    // Gray register is fed from the next binary value so Output and BinOut
    // move on the same edge.
    bin2gray_n #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            wrap_q <= wrap_d;
        end
    end

    assign Output   = gray_q;
    assign BinOut   = cnt_q;
    assign Overflow = ovf_q;
    assign Wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: a 3-bit clearable instance, a 3-bit
// non-clearable instance and an 8-bit instance share one set of controls.
module tb_gray_counter_n;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [2:0] loadval;
    logic       ovfclr;

    logic [2:0] out3, bin3;
    logic       ovf3, wrap3;
    logic [2:0] out3n, bin3n;
    logic       ovf3n, wrap3n;
    logic [7:0] out8, bin8;
    logic       ovf8, wrap8;

    int n_cmp = 0;
    int n_bad = 0;

    // Gray codes of 0..7, written out by hand.
    logic [2:0] g3 [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                           3'b110, 3'b111, 3'b101, 3'b100};

    gray_counter_n #(.WIDTH(3), .OVF_CLEARABLE(1'b1)) u_dut3 (
        .Clk (clk), .Reset (reset), .En (en), .Up (up), .Load (load),
        .LoadVal (loadval), .OvfClr (ovfclr), .Output (out3), .BinOut (bin3),
        .Overflow (ovf3), .Wrap (wrap3)
    );

    gray_counter_n #(.WIDTH(3), .OVF_CLEARABLE(1'b0)) u_dut3n (
        .Clk (clk), .Reset (reset), .En (en), .Up (up), .Load (load),
        .LoadVal (loadval), .OvfClr (ovfclr), .Output (out3n), .BinOut (bin3n),
        .Overflow (ovf3n), .Wrap (wrap3n)
    );

    gray_counter_n #(.WIDTH(8), .OVF_CLEARABLE(1'b1)) u_dut8 (
        .Clk (clk), .Reset (reset), .En (en), .Up (up), .Load (load),
        .LoadVal ({5'b0, loadval}), .OvfClr (ovfclr), .Output (out8),
        .BinOut (bin8), .Overflow (ovf8), .Wrap (wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string tag, input logic [2:0] b, input logic ovf,
                          input logic wr);
        check_eq({tag, "_bin"},  32'(bin3), 32'(b));
        check_eq({tag, "_gray"}, 32'(out3), 32'(g3[b]));
        check_eq({tag, "_ovf"},  32'(ovf3), 32'(ovf));
        check_eq({tag, "_wrap"}, 32'(wrap3), 32'(wr));
    endtask

    logic [7:0] prev8;

    initial begin
        reset   = 1'b0;
        en      = 1'b1;
        up      = 1'b1;
        load    = 1'b0;
        loadval = 3'd0;
        ovfclr  = 1'b0;

        // Reset held over two edges with En high: nothing may move.
        #20;
        check3("rst", 3'd0, 1'b0, 1'b0);
        check_eq("rst_out8", 32'(out8), 32'h0);
        #80;
        reset = 1'b1;

        // Count up through a full cycle; wrap on the eighth edge.
        for (int i = 1; i <= 8; i++) begin
            tick();
            check3("up", 3'(i % 8), (i == 8), (i == 8));
        end
        en = 1'b0;
        tick();
        check3("up_hold", 3'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges, then count down from zero.
        reset = 1'b0;
        #2;
        check3("arst1", 3'd0, 1'b0, 1'b0);
        reset = 1'b1;
        en    = 1'b1;
        up    = 1'b0;
        tick();
        check3("dn_wrap", 3'd7, 1'b1, 1'b1);
        check_eq("dn_wrap_gray_lit", 32'(out3), 32'b100);
        tick();
        check3("dn6", 3'd6, 1'b1, 1'b0);
        tick();
        check3("dn5", 3'd5, 1'b1, 1'b0);
        tick();
        check3("dn4", 3'd4, 1'b1, 1'b0);

        // Load beats En; Overflow untouched.
        load    = 1'b1;
        loadval = 3'd5;
        up      = 1'b1;
        tick();
        check3("load", 3'd5, 1'b1, 1'b0);
        check_eq("load_gray_lit", 32'(out3), 32'b111);
        load = 1'b0;
        tick();
        check3("after_load", 3'd6, 1'b1, 1'b0);
        check_eq("after_load_gray_lit", 32'(out3), 32'b101);
        tick();
        check3("to7", 3'd7, 1'b1, 1'b0);

        // OvfClr on a wrapping edge: set wins.
        ovfclr = 1'b1;
        tick();
        check3("clr_wrap", 3'd0, 1'b1, 1'b1);
        // OvfClr alone on a hold cycle.
        en = 1'b0;
        tick();
        check3("clr_hold", 3'd0, 1'b0, 1'b0);
        check_eq("nclr_ovf", 32'(ovf3n), 32'h1);
        check_eq("nclr_bin", 32'(bin3n), 32'h0);
        ovfclr = 1'b0;

        // Count to 4, then reset asynchronously mid-cycle.
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
        end
        check3("pre_arst", 3'd4, 1'b0, 1'b0);
        check_eq("pre_arst_nclr_ovf", 32'(ovf3n), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check3("arst2", 3'd0, 1'b0, 1'b0);
        check_eq("arst2_nclr_ovf", 32'(ovf3n), 32'h0);
        check_eq("arst2_nclr_bin", 32'(bin3n), 32'h0);
        #1;
        reset = 1'b1;
        tick();
        check3("resume", 3'd1, 1'b0, 1'b0);

        // 8-bit full cycle from reset.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        prev8 = out8;
        check_eq("w8_start", 32'(out8), 32'h0);
        for (int i = 1; i <= 256; i++) begin
            tick();
            check_eq("w8_onebit", 32'($countones(out8 ^ prev8)), 32'd1);
            check_eq("w8_gray", 32'(out8), 32'((i % 256) ^ ((i % 256) >> 1)));
            check_eq("w8_wrap", 32'(wrap8), 32'(i == 256));
            check_eq("w8_ovf", 32'(ovf8), 32'(i == 256));
            prev8 = out8;
        end
        en = 1'b0;
        tick();
        check_eq("w8_wrap_end", 32'(wrap8), 32'h0);
        check_eq("w8_ovf_end", 32'(ovf8), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
